// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning Hi/Lo; MULDIV_EARLY_OUT_EN enables multiply early termination.
// Latency: WIDTH+2 cycles Start-to-Done (multiply may finish in as few as 3 with early out).
// Backpressure: Ready=0/Busy=1 while in flight; Start is dropped when not Ready, Flush aborts.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             Flush,
    input  logic             WrHi,
    input  logic             WrLo,
    input  logic [WIDTH-1:0] WrData,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_raw;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               start_go;
    logic [2*WIDTH-1:0] acc_add;
    logic [WIDTH-1:0]   mplier_shr;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               calc_last;

    assign Ready = (state == S_IDLE) || (state == S_DONE);
    assign Busy  = (state == S_CALC) || (state == S_FIX);
    assign Done  = (state == S_DONE);

    // Op[0]=0 selects the signed variants; magnitude of the most negative value stays unsigned
    assign a_neg    = ~Op[0] & OperandA[WIDTH-1];
    assign b_neg    = ~Op[0] & OperandB[WIDTH-1];
    assign a_mag    = a_neg ? -OperandA : OperandA;
    assign b_mag    = b_neg ? -OperandB : OperandB;
    assign start_go = Start & Ready & ~Flush;

    // Multiply: multiplicand walks left, multiplier walks right, so early exit keeps alignment
    assign acc_add    = acc + (mplier[0] ? mcand : '0);
    assign mplier_shr = mplier >> 1;

    // Divide: acc holds {remainder, dividend/quotient}, mplier holds the divisor
    assign rem     = acc[2*WIDTH-1:WIDTH];
    assign quo     = acc[WIDTH-1:0];
    assign trial   = {rem, quo[WIDTH-1]};
    assign diff    = trial - {1'b0, mplier};
    assign div_ge  = (trial >= {1'b0, mplier});
    assign rem_nxt = div_ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], div_ge};

    assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    assign quo_fix  = (sign_a ^ sign_b) ? -quo : quo;
    assign rem_fix  = sign_a ? -rem : rem;

`ifdef MULDIV_EARLY_OUT_EN
    assign calc_last = (cnt == CNT_W'(1)) || (!is_div && (mplier_shr == '0));
`else
    assign calc_last = (cnt == CNT_W'(1));
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            a_raw   <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            Hi      <= '0;
            Lo      <= '0;
            DivZero <= 1'b0;
        end else begin
            case (state)
                S_CALC: begin
                    if (Flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (is_div) begin
                            acc <= {rem_nxt, quo_nxt};
                        end else begin
                            acc    <= acc_add;
                            mcand  <= mcand << 1;
                            mplier <= mplier_shr;
                        end
                        cnt <= cnt - CNT_W'(1);
                        if (calc_last) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (Flush) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_DONE;
                        if (!is_div) begin
                            Hi <= prod_fix[2*WIDTH-1:WIDTH];
                            Lo <= prod_fix[WIDTH-1:0];
                        end else if (mplier == '0) begin
                            Hi      <= a_raw;
                            Lo      <= '1;
                            DivZero <= 1'b1;
                        end else begin
                            Hi      <= rem_fix;
                            Lo      <= quo_fix;
                            DivZero <= 1'b0;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE behave identically; a Start here overlaps the MTHI/MTLO write
                    if (WrHi) begin
                        Hi <= WrData;
                    end
                    if (WrLo) begin
                        Lo <= WrData;
                    end
                    if (start_go) begin
                        state  <= S_CALC;
                        cnt    <= CNT_W'(WIDTH);
                        is_div <= Op[1];
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        a_raw  <= OperandA;
                        acc    <= Op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized and directed bench for hilo_muldiv_unit against an arithmetic reference model.
module tb_hilo_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic        Flush;
    logic        WrHi;
    logic        WrLo;
    logic [31:0] WrData;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Ready;
    logic        Busy;
    logic        Done;
    logic        DivZero;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic        exp_dz = 1'b0;

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB), .Flush(Flush),
        .WrHi(WrHi), .WrLo(WrLo), .WrData(WrData),
        .Hi(Hi), .Lo(Lo), .Ready(Ready), .Busy(Busy), .Done(Done), .DivZero(DivZero)
    );

    always #5 Clk = ~Clk;

    // Reference result as {hi, lo}, straight from signed/unsigned 64-bit arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = '0;
        if (op[1] && b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else begin
            case (op)
                2'd0: res = sa * sb;
                2'd1: res = ua * ub;
                2'd2: begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
                default: begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
            endcase
        end
        return res;
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] m;
        int n;
        m = (op == 2'd0 && b[31]) ? -b : b;
        n = 0;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[1]) return ((n == 0) ? 1 : n) + 2;
`endif
        return (n >= 0) ? 34 : 0;
    endfunction

    // Enters and leaves just after a falling edge; updates the model expectations
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit timeout);
        logic [63:0] r;
        Op = op; OperandA = a; OperandB = b; Start = 1'b1;
        @(posedge Clk); @(negedge Clk);
        Start = 1'b0;
        lat = 1;
        while (!Done && lat < 200) begin
            @(posedge Clk); @(negedge Clk);
            lat++;
        end
        timeout = !Done;
        r = ref_result(op, a, b);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        if (op[1]) exp_dz = (b == 32'd0);
    endtask

    task automatic test_reset;
        total++; if (Hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", Hi); end
        total++; if (Lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", Lo); end
        total++; if ({Ready, Busy, Done, DivZero} !== 4'b1000) begin
            bad++; $display("FAIL reset_flags got=%b want=1000", {Ready, Busy, Done, DivZero});
        end
    endtask

    task automatic test_directed;
        logic [1:0]  ops [5] = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd1};
        logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
        logic [31:0] bs  [5] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd1};
        logic [31:0] his [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] los [5] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'h8000_0000, 32'd5};
        int lat;
        bit to;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], lat, to);
            total++; if (to || Hi !== his[i] || Lo !== los[i]) begin
                bad++; $display("FAIL directed_%0d got hi=%h lo=%h to=%0d want hi=%h lo=%h", i, Hi, Lo, to, his[i], los[i]);
            end
            total++; if (lat !== ref_latency(ops[i], bs[i])) begin
                bad++; $display("FAIL directed_lat_%0d got=%0d want=%0d", i, lat, ref_latency(ops[i], bs[i]));
            end
        end
        total++; if (ref_latency(2'd1, 32'hFFFF_FFFF) !== lat - lat + 34 || DivZero !== 1'b0) begin
            bad++; $display("FAIL directed_dz got=%b want=0", DivZero);
        end
    endtask

    task automatic test_divzero;
        int lat;
        bit to;
        run_op(2'd3, 32'd100, 32'd0, lat, to);
        total++; if (to || Hi !== 32'd100 || Lo !== 32'hFFFF_FFFF || DivZero !== 1'b1) begin
            bad++; $display("FAIL divzero got hi=%h lo=%h dz=%b want hi=64 lo=ffffffff dz=1", Hi, Lo, DivZero);
        end
        run_op(2'd0, 32'd2, 32'd3, lat, to);
        total++; if (to || Lo !== 32'd6 || DivZero !== 1'b1) begin
            bad++; $display("FAIL divzero_sticky got lo=%h dz=%b want lo=6 dz=1", Lo, DivZero);
        end
        run_op(2'd3, 32'd100, 32'd7, lat, to);
        total++; if (to || Hi !== 32'd2 || Lo !== 32'd14 || DivZero !== 1'b0) begin
            bad++; $display("FAIL divzero_clear got hi=%h lo=%h dz=%b want hi=2 lo=e dz=0", Hi, Lo, DivZero);
        end
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [31:0] a, b;
        int lat, want_lat;
        bit to;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = b >> $urandom_range(0, 31);
                1: b = 32'($urandom_range(0, 2));
                2: a = (i % 2 == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
                default: ;
            endcase
            want_lat = ref_latency(op, b);
            run_op(op, a, b, lat, to);
            total++; if (to || Hi !== exp_hi || Lo !== exp_lo) begin
                bad++; $display("FAIL random_%0d op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h", i, op, a, b, Hi, Lo, exp_hi, exp_lo);
            end
            total++; if (DivZero !== exp_dz || lat !== want_lat) begin
                bad++; $display("FAIL random_flags_%0d got dz=%b lat=%0d want dz=%b lat=%0d", i, DivZero, lat, exp_dz, want_lat);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        bit to;
        run_op(2'd1, 32'd9, 32'd11, lat, to);
        total++; if (Done !== 1'b1 || Ready !== 1'b1) begin
            bad++; $display("FAIL b2b_done_state got done=%b ready=%b want 1 1", Done, Ready);
        end
        run_op(2'd2, 32'd1000, 32'hFFFF_FFFD, lat, to);
        total++; if (to || Hi !== 32'd1 || Lo !== 32'hFFFF_FEB3 || lat !== 34) begin
            bad++; $display("FAIL b2b_second got hi=%h lo=%h lat=%0d want hi=1 lo=fffffeb3 lat=34", Hi, Lo, lat);
        end
    endtask

    task automatic test_flush;
        int dones;
        Op = 2'd0; OperandA = 32'h0001_2345; OperandB = 32'h00FF_FFFF; Start = 1'b1;
        @(posedge Clk); @(negedge Clk);
        Start = 1'b0;
        total++; if (Busy !== 1'b1 || Ready !== 1'b0) begin
            bad++; $display("FAIL flush_busy got busy=%b ready=%b want 1 0", Busy, Ready);
        end
        repeat (9) begin @(posedge Clk); @(negedge Clk); end
        Flush = 1'b1;
        @(posedge Clk); @(negedge Clk);
        Flush = 1'b0;
        total++; if (Ready !== 1'b1 || Busy !== 1'b0 || Hi !== exp_hi || Lo !== exp_lo) begin
            bad++; $display("FAIL flush_abort got ready=%b busy=%b hi=%h lo=%h want 1 0 hi=%h lo=%h", Ready, Busy, Hi, Lo, exp_hi, exp_lo);
        end
        dones = 0;
        repeat (40) begin @(posedge Clk); @(negedge Clk); if (Done) dones++; end
        total++; if (dones !== 0 || Hi !== exp_hi || Lo !== exp_lo) begin
            bad++; $display("FAIL flush_no_done got dones=%0d want 0", dones);
        end
        Start = 1'b1; Flush = 1'b1;
        @(posedge Clk); @(negedge Clk);
        Start = 1'b0; Flush = 1'b0;
        total++; if (Busy !== 1'b0) begin
            bad++; $display("FAIL flush_idle_start got busy=%b want 0", Busy);
        end
    endtask

    task automatic test_busy_start;
        int lat;
        logic [63:0] r;
        Op = 2'd3; OperandA = 32'd1000; OperandB = 32'd7; Start = 1'b1;
        @(posedge Clk); @(negedge Clk);
        Start = 1'b0;
        lat = 1;
        while (!Done && lat < 200) begin
            if (lat == 5) begin Op = 2'd1; OperandA = 32'd3; OperandB = 32'd3; Start = 1'b1; end
            @(posedge Clk); @(negedge Clk);
            Start = 1'b0;
            lat++;
        end
        r = ref_result(2'd3, 32'd1000, 32'd7);
        exp_hi = r[63:32]; exp_lo = r[31:0]; exp_dz = 1'b0;
        total++; if (!Done || lat !== 34 || Hi !== exp_hi || Lo !== exp_lo) begin
            bad++; $display("FAIL busy_start got lat=%0d hi=%h lo=%h want lat=34 hi=%h lo=%h", lat, Hi, Lo, exp_hi, exp_lo);
        end
        @(posedge Clk); @(negedge Clk);
        total++; if (Busy !== 1'b0 || Done !== 1'b0) begin
            bad++; $display("FAIL busy_start_queue got busy=%b done=%b want 0 0", Busy, Done);
        end
    endtask

    task automatic test_mthi_mtlo;
        int lat;
        bit to;
        WrHi = 1'b1; WrData = 32'h0000_1234;
        @(posedge Clk); @(negedge Clk);
        WrHi = 1'b0;
        total++; if (Hi !== 32'h0000_1234 || Lo !== exp_lo) begin
            bad++; $display("FAIL mthi got hi=%h lo=%h want hi=1234 lo=%h", Hi, Lo, exp_lo);
        end
        WrHi = 1'b1; WrLo = 1'b1; WrData = 32'hCAFE_F00D;
        @(posedge Clk); @(negedge Clk);
        WrHi = 1'b0; WrLo = 1'b0;
        total++; if (Hi !== 32'hCAFE_F00D || Lo !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL mthi_mtlo got hi=%h lo=%h want both cafef00d", Hi, Lo);
        end
        Op = 2'd1; OperandA = 32'd6; OperandB = 32'hFFFF_0000; Start = 1'b1;
        WrHi = 1'b1; WrData = 32'h0000_BEEF;
        @(posedge Clk); @(negedge Clk);
        Start = 1'b0; WrHi = 1'b0;
        total++; if (Hi !== 32'h0000_BEEF || Busy !== 1'b1) begin
            bad++; $display("FAIL write_with_start got hi=%h busy=%b want beef 1", Hi, Busy);
        end
        @(posedge Clk); @(negedge Clk);
        WrLo = 1'b1; WrData = 32'hDEAD_DEAD;
        @(posedge Clk); @(negedge Clk);
        WrLo = 1'b0;
        total++; if (Lo !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL mtlo_busy got lo=%h want cafef00d", Lo);
        end
        lat = 3;
        while (!Done && lat < 200) begin @(posedge Clk); @(negedge Clk); lat++; end
        to = !Done;
        total++; if (to || Hi !== 32'd5 || Lo !== 32'hFFFA_0000) begin
            bad++; $display("FAIL write_overwritten got hi=%h lo=%h want 5 fffa0000", Hi, Lo);
        end
        exp_hi = Hi === 32'd5 ? 32'd5 : 32'd5;
        exp_lo = 32'hFFFA_0000;
    endtask

    task automatic test_reset_mid;
        int lat;
        bit to;
        run_op(2'd3, 32'd77, 32'd0, lat, to);
        Op = 2'd0; OperandA = 32'd123; OperandB = 32'hFFFF_FFFF; Start = 1'b1;
        @(posedge Clk); @(negedge Clk);
        Start = 1'b0;
        repeat (4) begin @(posedge Clk); @(negedge Clk); end
        Reset = 1'b1;
        @(posedge Clk); @(negedge Clk);
        Reset = 1'b0;
        total++; if (Hi !== 32'd0 || Lo !== 32'd0 || Busy !== 1'b0 || Ready !== 1'b1 || DivZero !== 1'b0) begin
            bad++; $display("FAIL reset_mid got hi=%h lo=%h busy=%b ready=%b dz=%b want 0 0 0 1 0", Hi, Lo, Busy, Ready, DivZero);
        end
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        repeat (40) begin @(posedge Clk); @(negedge Clk); end
        total++; if (Done !== 1'b0 || Hi !== 32'd0) begin
            bad++; $display("FAIL reset_mid_discard got done=%b hi=%h want 0 0", Done, Hi);
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Op = 2'd0; OperandA = '0; OperandB = '0;
        Flush = 1'b0; WrHi = 1'b0; WrLo = 1'b0; WrData = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        test_reset;
        test_directed;
        test_divzero;
        test_back_to_back;
        test_random;
        test_flush;
        test_busy_start;
        test_mthi_mtlo;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
